// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the instruction-fetch port and
// the data load/store port. Each access is an ISSUE cycle (memory command),
// followed by a fixed-latency WAIT, and ends with a one-cycle response to the
// port that owns the access. The next access can be arbitrated on the response
// edge, so back-to-back accesses run at one per MEM_LAT + 1 cycles.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   : round-robin on a tie, using a last_owner flop.
//                  undefined : fixed priority, data wins over fetch.
//
// Parameters:
//   ADDR_W   address width of all ports
//   DATA_W   data width; byte-enable width is DATA_W/8
//   MEM_LAT  cycles from the memory command to valid m_rdata (>= 1)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             fetch request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata   fetch grant pulse, response pulse, read data
//   d_req/d_we/d_be/d_addr/d_wdata   data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata   data grant pulse, response/write-ack, load data
//   m_en/m_we/m_be/m_addr/m_wdata    memory command (m_en only in ISSUE)
//   m_rdata                  memory read data, valid MEM_LAT cycles after m_en
//   busy                     high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  // data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  // memory macro
  output logic                  m_en,
  output logic                  m_we,
  output logic [DATA_W/8-1:0]   m_be,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic [DATA_W-1:0]     m_rdata,
  // status
  output logic                  busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;

  logic               m_en_q, m_en_d;
  logic               m_we_q, m_we_d;
  logic [BE_W-1:0]    m_be_q, m_be_d;
  logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
  logic [DATA_W-1:0]  m_wdata_q, m_wdata_d;
  logic               i_gnt_q, i_gnt_d;
  logic               d_gnt_q, d_gnt_d;
  logic               i_rvalid_q, i_rvalid_d;
  logic               d_rvalid_q, d_rvalid_d;
  logic               busy_q, busy_d;

  logic               any_req;
  logic               resp_cyc;
  logic               arb_fire;
  logic               win_data;
  logic               rsp_next;

  assign any_req  = i_req | d_req;
  // Final WAIT cycle: memory data is valid and the next access may be arbitrated.
  assign resp_cyc = (state_q == ST_WAIT) && (lat_cnt_q == CNT_W'(1));

  // Winner selection (1 = data port)
`ifdef MEM_ARB_RR_EN
  logic last_owner_q;

  always_comb begin : winner_rr
    win_data = d_req;
    if (d_req && i_req) begin
      win_data = (last_owner_q == OWN_FETCH);
    end
  end

  // Owner of the most recent ISSUE, used to break the next tie.
  always_ff @(posedge clk) begin : last_owner_reg
    if (rst) begin
      last_owner_q <= OWN_FETCH;
    end else if (arb_fire) begin
      last_owner_q <= win_data;
    end
  end
`else
  assign win_data = d_req;
`endif

  // State register
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; arb_fire marks an arbitration edge
  always_comb begin : next_state
    state_d  = state_q;
    arb_fire = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d  = ST_ISSUE;
          arb_fire = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (resp_cyc) begin
          if (any_req) begin
            state_d  = ST_ISSUE;
            arb_fire = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs and datapath
  always_comb begin : output_next
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;

    // Command fields are captured on the arbitration edge and held afterwards.
    if (arb_fire) begin
      owner_d = win_data;
      if (win_data) begin
        m_we_d    = d_we;
        m_be_d    = d_be;
        m_addr_d  = d_addr;
        m_wdata_d = d_wdata;
      end else begin
        m_we_d    = 1'b0;
        m_be_d    = {BE_W{1'b1}};
        m_addr_d  = i_addr;
        m_wdata_d = {DATA_W{1'b0}};
      end
    end

    if (state_q == ST_ISSUE) begin
      lat_cnt_d = CNT_W'(MEM_LAT);
    end else if (state_q == ST_WAIT) begin
      lat_cnt_d = lat_cnt_q - CNT_W'(1);
    end

    // Pulses are registered, so decode them from the state being entered.
    rsp_next   = (state_d == ST_WAIT) && (lat_cnt_d == CNT_W'(1));
    m_en_d     = (state_d == ST_ISSUE);
    i_gnt_d    = m_en_d && (owner_d == OWN_FETCH);
    d_gnt_d    = m_en_d && (owner_d == OWN_DATA);
    i_rvalid_d = rsp_next && (owner_d == OWN_FETCH);
    d_rvalid_d = rsp_next && (owner_d == OWN_DATA);
    busy_d     = (state_d != ST_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin : out_regs
    if (rst) begin
      owner_q    <= OWN_FETCH;
      lat_cnt_q  <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      lat_cnt_q  <= lat_cnt_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_be_q     <= m_be_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      busy_q     <= busy_d;
    end
  end

  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_be     = m_be_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign i_gnt    = i_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign busy     = busy_q;

  // Read data is only passed through in the owner's response cycle; a store
  // response is a pure acknowledge and returns zero.
  assign i_rdata = i_rvalid_q ? m_rdata : {DATA_W{1'b0}};
  assign d_rdata = (d_rvalid_q && !m_we_q) ? m_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiter instances (MEM_LAT = 2 and MEM_LAT = 1) share the clock and reset.
// A transaction-level reference model per instance predicts every output on
// every cycle; directed sequences add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned NI = 2;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic          i_req      [NI];
  logic [AW-1:0] i_addr     [NI];
  logic          d_req      [NI];
  logic          d_we       [NI];
  logic [BW-1:0] d_be       [NI];
  logic [AW-1:0] d_addr     [NI];
  logic [DW-1:0] d_wdata    [NI];
  logic [DW-1:0] m_rdata    [NI];

  logic          i_gnt_w    [NI];
  logic          i_rvalid_w [NI];
  logic [DW-1:0] i_rdata_w  [NI];
  logic          d_gnt_w    [NI];
  logic          d_rvalid_w [NI];
  logic [DW-1:0] d_rdata_w  [NI];
  logic          m_en_w     [NI];
  logic          m_we_w     [NI];
  logic [BW-1:0] m_be_w     [NI];
  logic [AW-1:0] m_addr_w   [NI];
  logic [DW-1:0] m_wdata_w  [NI];
  logic          busy_w     [NI];

  bit            ig_seen    [NI];
  bit            dg_seen    [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int inst, input string nm,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0h expected %0h (cycle %0d)",
               inst, nm, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // DUTs and per-instance reference model
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int unsigned LAT = (g == 0) ? 2 : 1;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req[g]),
      .i_addr   (i_addr[g]),
      .i_gnt    (i_gnt_w[g]),
      .i_rvalid (i_rvalid_w[g]),
      .i_rdata  (i_rdata_w[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_be     (d_be[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_gnt    (d_gnt_w[g]),
      .d_rvalid (d_rvalid_w[g]),
      .d_rdata  (d_rdata_w[g]),
      .m_en     (m_en_w[g]),
      .m_we     (m_we_w[g]),
      .m_be     (m_be_w[g]),
      .m_addr   (m_addr_w[g]),
      .m_wdata  (m_wdata_w[g]),
      .m_rdata  (m_rdata[g]),
      .busy     (busy_w[g])
    );

    // One access in flight at most: it is granted in cycle t_gnt, answered in
    // cycle t_rv = t_gnt + LAT, and the slot frees at the end of t_rv.
    bit            live     = 1'b0;
    bit            tv       = 1'b0;
    bit            t_own    = 1'b0;
    bit            t_we     = 1'b0;
    bit            last_own = 1'b0;
    int unsigned   t_gnt    = 0;
    int unsigned   t_rv     = 0;
    logic [BW-1:0] t_be     = '0;
    logic [AW-1:0] t_addr   = '0;
    logic [DW-1:0] t_wdata  = '0;
    bit            e_we     = 1'b0;
    logic [BW-1:0] e_be     = '0;
    logic [AW-1:0] e_addr   = '0;
    logic [DW-1:0] e_wdata  = '0;

    always @(negedge clk) begin : model
      bit            issue, resp, free, win, nwe;
      logic [BW-1:0] nbe;
      logic [AW-1:0] naddr;
      logic [DW-1:0] nwdata;
      issue  = tv && (cyc == t_gnt);
      resp   = tv && (cyc == t_rv);
      nwe    = issue ? t_we    : e_we;
      nbe    = issue ? t_be    : e_be;
      naddr  = issue ? t_addr  : e_addr;
      nwdata = issue ? t_wdata : e_wdata;
      if (live) begin
        chk(g, "m_cmd", {m_en_w[g], m_we_w[g], m_be_w[g], m_addr_w[g], m_wdata_w[g]},
                        {issue, nwe, nbe, naddr, nwdata});
        chk(g, "gnt", {i_gnt_w[g], d_gnt_w[g]}, {issue && !t_own, issue && t_own});
        chk(g, "rvalid", {i_rvalid_w[g], d_rvalid_w[g]}, {resp && !t_own, resp && t_own});
        chk(g, "i_rdata", i_rdata_w[g], (resp && !t_own) ? m_rdata[g] : {DW{1'b0}});
        chk(g, "d_rdata", d_rdata_w[g], (resp && t_own && !t_we) ? m_rdata[g] : {DW{1'b0}});
        chk(g, "busy", busy_w[g], tv && (cyc >= t_gnt) && (cyc <= t_rv));
      end
      e_we    <= nwe;
      e_be    <= nbe;
      e_addr  <= naddr;
      e_wdata <= nwdata;
      if (rst) begin
        live     <= 1'b1;
        tv       <= 1'b0;
        last_own <= 1'b0;
        e_we     <= 1'b0;
        e_be     <= '0;
        e_addr   <= '0;
        e_wdata  <= '0;
      end else if (live) begin
        free = !tv || resp;
        if (free && (i_req[g] || d_req[g])) begin
          win      = (RR && i_req[g] && d_req[g]) ? !last_own : d_req[g];
          tv       <= 1'b1;
          t_gnt    <= cyc + 1;
          t_rv     <= cyc + 1 + LAT;
          t_own    <= win;
          last_own <= win;
          t_we     <= win ? d_we[g]    : 1'b0;
          t_be     <= win ? d_be[g]    : {BW{1'b1}};
          t_addr   <= win ? d_addr[g]  : i_addr[g];
          t_wdata  <= win ? d_wdata[g] : {DW{1'b0}};
        end else if (resp) begin
          tv <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int g = 0; g < NI; g++) begin
      i_req[g]   = 1'b0;
      i_addr[g]  = '0;
      d_req[g]   = 1'b0;
      d_we[g]    = 1'b0;
      d_be[g]    = '0;
      d_addr[g]  = '0;
      d_wdata[g] = '0;
      m_rdata[g] = '0;
    end
  endtask

  // Reset across one clock edge, then one idle cycle; returns with inputs
  // for the next cycle ("cycle 0" of a test) open for driving.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [127:0] all_out(input int g);
    return {m_en_w[g], m_we_w[g], m_be_w[g], m_addr_w[g], m_wdata_w[g],
            i_gnt_w[g], d_gnt_w[g], i_rvalid_w[g], d_rvalid_w[g], busy_w[g]};
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    do_reset();
    at_neg();
    chk(0, "reset outputs", all_out(0), 128'h0);
    chk(1, "reset outputs", all_out(1), 128'h0);

    // Fetch only, LAT 2
    tick();
    i_req[0] = 1'b1; i_addr[0] = 32'h100;                        // c0
    tick(); at_neg();                                            // c1
    chk(0, "t1 m_en", m_en_w[0], 1);
    chk(0, "t1 m_addr", m_addr_w[0], 32'h100);
    chk(0, "t1 m_be", m_be_w[0], 4'hF);
    chk(0, "t1 i_gnt", i_gnt_w[0], 1);
    tick(); i_req[0] = 1'b0; m_rdata[0] = 32'hDEADBEEF;          // c2
    tick(); at_neg();                                            // c3
    chk(0, "t1 i_rvalid", i_rvalid_w[0], 1);
    chk(0, "t1 i_rdata", i_rdata_w[0], 32'hDEADBEEF);
    tick(); tick();

    // Store, LAT 2
    do_reset();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_be[0] = 4'h3;
    d_addr[0] = 32'h40; d_wdata[0] = 32'h1234;                   // c0
    tick(); at_neg();                                            // c1
    chk(0, "t2 m_we", m_we_w[0], 1);
    chk(0, "t2 m_be", m_be_w[0], 4'h3);
    chk(0, "t2 m_wdata", m_wdata_w[0], 32'h1234);
    chk(0, "t2 d_gnt", d_gnt_w[0], 1);
    tick(); d_req[0] = 1'b0; m_rdata[0] = 32'hCAFEF00D;          // c2
    tick(); at_neg();                                            // c3
    chk(0, "t2 d_rvalid", d_rvalid_w[0], 1);
    chk(0, "t2 d_rdata", d_rdata_w[0], 32'h0);
    tick(); tick();

    // Both requesting once: data first, fetch follows without a bubble
    do_reset();
    d_we[0] = 1'b0; d_be[0] = 4'hF; d_addr[0] = 32'h600;
    i_addr[0] = 32'h500; d_req[0] = 1'b1; i_req[0] = 1'b1;       // c0
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 2) d_req[0] = 1'b0;
      if (k == 5) i_req[0] = 1'b0;
      at_neg();
      if (k == 1) chk(0, "t3 gnt c1", {i_gnt_w[0], d_gnt_w[0]}, 2'b01);
      if (k == 3) chk(0, "t3 d_rvalid c3", d_rvalid_w[0], 1);
      if (k == 4) chk(0, "t3 gnt c4", {i_gnt_w[0], d_gnt_w[0]}, 2'b10);
      if (k == 4) chk(0, "t3 m_addr c4", m_addr_w[0], 32'h500);
      if (k == 6) chk(0, "t3 i_rvalid c6", i_rvalid_w[0], 1);
    end
    tick();

    // Both requesting continuously: RR alternates d,i,d,i; fixed always d
    do_reset();
    d_req[0] = 1'b1; i_req[0] = 1'b1;                            // c0
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 11) begin d_req[0] = 1'b0; i_req[0] = 1'b0; end
      at_neg();
      if ((k % 3 == 1) && (k <= 10)) begin
        bit exp_d;
        exp_d = RR ? (((k - 1) / 3) % 2 == 0) : 1'b1;
        chk(0, "t4 gnt sequence", {i_gnt_w[0], d_gnt_w[0]}, {!exp_d, exp_d});
      end
    end
    tick();

    // LAT 1 fetch, with a back-to-back second request
    do_reset();
    i_req[1] = 1'b1; i_addr[1] = 32'h300;                        // c0
    tick(); at_neg();                                            // c1
    chk(1, "t5 i_gnt c1", i_gnt_w[1], 1);
    chk(1, "t5 m_addr c1", m_addr_w[1], 32'h300);
    tick(); i_addr[1] = 32'h304; at_neg();                       // c2
    chk(1, "t5 i_rvalid c2", i_rvalid_w[1], 1);
    tick(); at_neg();                                            // c3
    chk(1, "t5 i_gnt c3", i_gnt_w[1], 1);
    chk(1, "t5 m_addr c3", m_addr_w[1], 32'h304);
    tick(); i_req[1] = 1'b0; at_neg();                           // c4
    chk(1, "t5 i_rvalid c4", i_rvalid_w[1], 1);
    tick(); at_neg();                                            // c5
    chk(1, "t5 busy c5", busy_w[1], 0);
    tick();

    // Reset in the cycle after d_gnt abandons the load
    do_reset();
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_be[0] = 4'hF; d_addr[0] = 32'h80;  // c0
    tick(); at_neg();                                            // c1
    chk(0, "t6 d_gnt c1", d_gnt_w[0], 1);
    tick(); rst = 1'b1; d_req[0] = 1'b0; m_rdata[0] = 32'h55AA55AA; // c2
    tick(); rst = 1'b0; at_neg();                                // c3
    chk(0, "t6 outputs after rst", all_out(0), 128'h0);
    chk(0, "t6 d_rdata after rst", d_rdata_w[0], 32'h0);
    chk(0, "t6 i_rdata after rst", i_rdata_w[0], 32'h0);
    tick(); i_req[0] = 1'b1; i_addr[0] = 32'h200; at_neg();      // c4
    chk(0, "t6 d_rvalid c4", d_rvalid_w[0], 0);
    tick(); at_neg();                                            // c5
    chk(0, "t6 i_gnt c5", i_gnt_w[0], 1);
    chk(0, "t6 m_addr c5", m_addr_w[0], 32'h200);
    chk(0, "t6 d_rvalid c5", d_rvalid_w[0], 0);
    tick(); i_req[0] = 1'b0; at_neg();                           // c6
    chk(0, "t6 d_rvalid c6", d_rvalid_w[0], 0);
    tick(); at_neg();                                            // c7
    chk(0, "t6 i_rvalid c7", i_rvalid_w[0], 1);
    chk(0, "t6 i_rdata c7", i_rdata_w[0], 32'h55AA55AA);
    tick();

    // Randomized traffic on both instances, with occasional resets
    clear_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      at_neg();
      for (int g = 0; g < NI; g++) begin
        ig_seen[g] = (i_gnt_w[g] === 1'b1);
        dg_seen[g] = (d_gnt_w[g] === 1'b1);
      end
      tick();
      rst = ($urandom_range(0, 399) == 0);
      for (int g = 0; g < NI; g++) begin
        bit was_i, was_d;
        was_i = i_req[g];
        was_d = d_req[g];
        m_rdata[g] = $urandom();
        if (was_i && ig_seen[g]) i_req[g] = ($urandom_range(0, 3) == 0);
        else if (!was_i)         i_req[g] = ($urandom_range(0, 2) == 0);
        if (i_req[g] && (!was_i || ig_seen[g])) i_addr[g] = $urandom();
        if (was_d && dg_seen[g]) d_req[g] = ($urandom_range(0, 3) == 0);
        else if (!was_d)         d_req[g] = ($urandom_range(0, 2) == 0);
        if (d_req[g] && (!was_d || dg_seen[g])) begin
          d_we[g]    = $urandom_range(0, 1) == 1;
          d_be[g]    = BW'($urandom());
          d_addr[g]  = $urandom();
          d_wdata[g] = $urandom();
        end
      end
    end

    rst = 1'b0;
    clear_inputs();
    repeat (10) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
